// File: rtl/sim_run_controller_if.sv
// Harness-side bundle for sim_run_controller: halt/pause inputs and run status outputs.
// The master modport is the controller side; slave is the harness side.
interface sim_run_controller_if #(
  parameter int CNT_WIDTH = 16,
  parameter int NUM_HALT  = 2
);
  logic [NUM_HALT-1:0]  halt_req;
  logic                 pause;
  logic                 dut_reset;
  logic                 run;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic                 done;
  logic                 timeout;
  logic [NUM_HALT-1:0]  halt_src;
  logic                 finish_pulse;

  modport master (
    input  halt_req, pause,
    output dut_reset, run, cycle_count, done, timeout, halt_src, finish_pulse
  );

  modport slave (
    output halt_req, pause,
    input  dut_reset, run, cycle_count, done, timeout, halt_src, finish_pulse
  );
endinterface

// File: rtl/sim_run_controller.sv
// Simulation run controller: multi-cycle core reset, run-cycle counting, halt drain and timeout.
// Optional SIM_FINISH_EN: report the end-of-run cause and call $finish on the finish pulse.
module sim_run_controller #(
  parameter int CNT_WIDTH    = 16,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 30,
  parameter int DRAIN_CYCLES = 4,
  parameter int NUM_HALT     = 2
) (
  input logic                 clk,
  input logic                 reset,
  sim_run_controller_if.master bus
);

  localparam int RST_W   = $clog2(RESET_CYCLES + 1);
  localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [CNT_WIDTH-1:0] MAX_LAST   = CNT_WIDTH'(MAX_CYCLES - 1);
  localparam logic [RST_W-1:0]     RST_LAST   = RST_W'(RESET_CYCLES - 1);
  localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
    $error("sim_run_controller: RESET_CYCLES must be >= 1");
  end
  if (MAX_CYCLES < 0 || (longint'(MAX_CYCLES) >> CNT_WIDTH) != 0) begin : g_bad_max_cycles
    $error("sim_run_controller: MAX_CYCLES must fit below 2**CNT_WIDTH");
  end

  typedef enum logic [1:0] {
    ST_RST,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [RST_W-1:0]     rst_cnt;
  logic [RST_W-1:0]     rst_cnt_next;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [DRAIN_W-1:0]   drain_cnt_next;
  logic [CNT_WIDTH-1:0] count_next;
  logic [NUM_HALT-1:0]  halt_src_next;
  logic                 timeout_next;
  logic                 dut_reset_next;
  logic                 run_next;
  logic                 done_next;
  logic                 finish_next;

  logic halt_any;
  logic rst_last;
  logic drain_last;
  logic timeout_hit;
  logic count_sat;

  assign halt_any    = |bus.halt_req;
  assign rst_last    = (rst_cnt == RST_LAST);
  assign drain_last  = (drain_cnt == DRAIN_LAST);
  assign count_sat   = &bus.cycle_count;
  // A paused edge is not a counted cycle, so it can never trigger the timeout.
  assign timeout_hit = (MAX_CYCLES != 0) && !bus.pause && (bus.cycle_count == MAX_LAST);

  always_ff @(posedge clk) begin : state_register
    if (reset) begin
      state            <= ST_RST;
      rst_cnt          <= '0;
      drain_cnt        <= '0;
      bus.dut_reset    <= 1'b1;
      bus.run          <= 1'b0;
      bus.cycle_count  <= '0;
      bus.done         <= 1'b0;
      bus.timeout      <= 1'b0;
      bus.halt_src     <= '0;
      bus.finish_pulse <= 1'b0;
    end else begin
      state            <= state_next;
      rst_cnt          <= rst_cnt_next;
      drain_cnt        <= drain_cnt_next;
      bus.dut_reset    <= dut_reset_next;
      bus.run          <= run_next;
      bus.cycle_count  <= count_next;
      bus.done         <= done_next;
      bus.timeout      <= timeout_next;
      bus.halt_src     <= halt_src_next;
      bus.finish_pulse <= finish_next;
    end
  end

  // Halt outranks timeout when both land on the same RUN edge.
  always_comb begin : next_state_logic
    state_next = state;
    unique case (state)
      ST_RST:   if (rst_last) state_next = ST_RUN;
      ST_RUN: begin
        if (halt_any)         state_next = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
        else if (timeout_hit) state_next = ST_DONE;
      end
      ST_DRAIN: if (drain_last) state_next = ST_DONE;
      default:  ;
    endcase
  end

  always_comb begin : output_logic
    rst_cnt_next   = rst_cnt;
    drain_cnt_next = drain_cnt;
    count_next     = bus.cycle_count;
    timeout_next   = bus.timeout;
    halt_src_next  = bus.halt_src;
    unique case (state)
      ST_RST: rst_cnt_next = rst_cnt + 1'b1;
      ST_RUN, ST_DRAIN: begin
        if (!bus.pause && !count_sat) count_next = bus.cycle_count + 1'b1;
        halt_src_next = bus.halt_src | bus.halt_req;
        if (state == ST_DRAIN) drain_cnt_next = drain_cnt + 1'b1;
        else if (halt_any)     drain_cnt_next = '0;
        else if (timeout_hit)  timeout_next = 1'b1;
      end
      default: ;
    endcase
    dut_reset_next = (state_next == ST_RST);
    run_next       = (state_next == ST_RUN) || (state_next == ST_DRAIN);
    done_next      = (state_next == ST_DONE);
    finish_next    = (state_next == ST_DONE) && (state != ST_DONE);
  end

`ifdef SIM_FINISH_EN
  always @(posedge clk) begin : sim_finish
    if (!reset && bus.finish_pulse) begin
      if (bus.timeout)
        $display("sim_run_controller: TIMEOUT cycle_count=%0d time=%0t", bus.cycle_count, $time);
      else
        $display("sim_run_controller: HALT halt_src=%b cycle_count=%0d time=%0t",
                 bus.halt_src, bus.cycle_count, $time);
      $finish;
    end
  end
`else
  // End of run is visible only through done and finish_pulse.
`endif

endmodule

// File: tb/tb_sim_run_controller.sv
// Bench for sim_run_controller: a default-parameter instance and a CNT_WIDTH=4 / no-timeout / no-drain
// instance, each checked every cycle against a behavioural model plus directed literal expectations.
module tb_sim_run_controller;

  logic clk;
  logic reset_a;
  logic reset_b;
  int   tests;
  int   fails;

  typedef struct {
    bit valid;
    int rst_left;
    bit dut_reset;
    bit running;
    int drain_left;
    bit done;
    int count;
    bit timeout;
    int halt_src;
    bit pulse;
  } model_t;

  model_t ma;
  model_t mb;

  sim_run_controller_if #(.CNT_WIDTH(16), .NUM_HALT(2)) bus_a ();
  sim_run_controller_if #(.CNT_WIDTH(4),  .NUM_HALT(2)) bus_b ();

  sim_run_controller #(
    .CNT_WIDTH(16), .RESET_CYCLES(2), .MAX_CYCLES(30), .DRAIN_CYCLES(4), .NUM_HALT(2)
  ) dut_a (
    .clk(clk), .reset(reset_a), .bus(bus_a.master)
  );

  sim_run_controller #(
    .CNT_WIDTH(4), .RESET_CYCLES(2), .MAX_CYCLES(0), .DRAIN_CYCLES(0), .NUM_HALT(2)
  ) dut_b (
    .clk(clk), .reset(reset_b), .bus(bus_b.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Countdown view of a run: reset edges left, drain edges left, then done.
  function automatic model_t model_step(model_t m, bit rst, int halt, bit pause_v,
                                        int max_c, int drain_c, int cnt_max, int reset_c);
    model_t n;
    bit     finish;
    int     prev;
    n       = m;
    finish  = 1'b0;
    n.pulse = 1'b0;
    if (rst) begin
      n.valid      = 1'b1;
      n.rst_left   = reset_c;
      n.dut_reset  = 1'b1;
      n.running    = 1'b0;
      n.drain_left = 0;
      n.done       = 1'b0;
      n.count      = 0;
      n.timeout    = 1'b0;
      n.halt_src   = 0;
    end else if (m.valid && !m.done) begin
      if (m.rst_left > 0) begin
        n.rst_left = m.rst_left - 1;
        if (n.rst_left == 0) begin
          n.dut_reset = 1'b0;
          n.running   = 1'b1;
        end
      end else begin
        prev = m.count;
        if (!pause_v && m.count < cnt_max) n.count = m.count + 1;
        if (m.drain_left > 0) begin
          n.halt_src   = m.halt_src | halt;
          n.drain_left = m.drain_left - 1;
          finish       = (n.drain_left == 0);
        end else if (halt != 0) begin
          n.halt_src = m.halt_src | halt;
          if (drain_c == 0) finish = 1'b1;
          else n.drain_left = drain_c;
        end else if (max_c != 0 && !pause_v && prev == max_c - 1) begin
          n.timeout = 1'b1;
          finish    = 1'b1;
        end
      end
    end
    if (finish) begin
      n.running = 1'b0;
      n.done    = 1'b1;
      n.pulse   = 1'b1;
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    tests++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input bit sel_b, input bit rst, input logic [1:0] halt,
                               input bit pause_v, input int cycles);
    if (sel_b) begin
      reset_b        = rst;
      bus_b.halt_req = halt;
      bus_b.pause    = pause_v;
    end else begin
      reset_a        = rst;
      bus_a.halt_req = halt;
      bus_a.pause    = pause_v;
    end
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitDone(input bit sel_b, input int budget, output int edges);
    edges = 0;
    while ((sel_b ? bus_b.done : bus_a.done) !== 1'b1 && edges < budget) begin
      @(negedge clk);
      edges++;
    end
    if ((sel_b ? bus_b.done : bus_a.done) !== 1'b1)
      checkOutput("wait_done_budget", 32'(edges), 32'(budget + 1));
  endtask

  always @(posedge clk) begin
    ma = model_step(ma, reset_a, int'(bus_a.halt_req), bus_a.pause, 30, 4, 65535, 2);
    mb = model_step(mb, reset_b, int'(bus_b.halt_req), bus_b.pause, 0, 0, 15, 2);
  end

  always @(negedge clk) begin
    if (ma.valid) begin
      checkOutput("a.dut_reset",    32'(bus_a.dut_reset),    32'(ma.dut_reset));
      checkOutput("a.run",          32'(bus_a.run),          32'(ma.running));
      checkOutput("a.cycle_count",  32'(bus_a.cycle_count),  32'(ma.count));
      checkOutput("a.done",         32'(bus_a.done),         32'(ma.done));
      checkOutput("a.timeout",      32'(bus_a.timeout),      32'(ma.timeout));
      checkOutput("a.halt_src",     32'(bus_a.halt_src),     32'(ma.halt_src));
      checkOutput("a.finish_pulse", 32'(bus_a.finish_pulse), 32'(ma.pulse));
    end
    if (mb.valid) begin
      checkOutput("b.dut_reset",    32'(bus_b.dut_reset),    32'(mb.dut_reset));
      checkOutput("b.run",          32'(bus_b.run),          32'(mb.running));
      checkOutput("b.cycle_count",  32'(bus_b.cycle_count),  32'(mb.count));
      checkOutput("b.done",         32'(bus_b.done),         32'(mb.done));
      checkOutput("b.timeout",      32'(bus_b.timeout),      32'(mb.timeout));
      checkOutput("b.halt_src",     32'(bus_b.halt_src),     32'(mb.halt_src));
      checkOutput("b.finish_pulse", 32'(bus_b.finish_pulse), 32'(mb.pulse));
    end
  end

  initial begin
    int edges;
    tests = 0;
    fails = 0;
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 0);

    // Timeout after 30 run edges, with a two-edge core reset first
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 3);
    checkOutput("s1_rst_dut_reset", 32'(bus_a.dut_reset), 32'd1);
    checkOutput("s1_rst_run",       32'(bus_a.run),       32'd0);
    checkOutput("s1_rst_count",     32'(bus_a.cycle_count), 32'd0);
    checkOutput("s1_rst_done",      32'(bus_a.done),      32'd0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1);
    checkOutput("s1_edge1_dut_reset", 32'(bus_a.dut_reset), 32'd1);
    checkOutput("s1_edge1_run",       32'(bus_a.run),       32'd0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1);
    checkOutput("s1_edge2_dut_reset", 32'(bus_a.dut_reset), 32'd0);
    checkOutput("s1_edge2_run",       32'(bus_a.run),       32'd1);
    checkOutput("s1_edge2_count",     32'(bus_a.cycle_count), 32'd0);
    waitDone(1'b0, 40, edges);
    checkOutput("s1_run_edges", 32'(edges), 32'd30);
    checkOutput("s1_count",     32'(bus_a.cycle_count), 32'd30);
    checkOutput("s1_timeout",   32'(bus_a.timeout),     32'd1);
    checkOutput("s1_pulse",     32'(bus_a.finish_pulse), 32'd1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1);
    checkOutput("s1_pulse_drop", 32'(bus_a.finish_pulse), 32'd0);
    checkOutput("s1_done_hold",  32'(bus_a.done),         32'd1);
    checkOutput("s1_count_hold", 32'(bus_a.cycle_count),  32'd30);

    // Halt on channel 1 at count 10, then four drain edges
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 12);
    checkOutput("s2_count_pre", 32'(bus_a.cycle_count), 32'd10);
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 1);
    checkOutput("s2_drain_count", 32'(bus_a.cycle_count), 32'd11);
    checkOutput("s2_drain_run",   32'(bus_a.run),         32'd1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 3);
    checkOutput("s2_not_done", 32'(bus_a.done), 32'd0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1);
    checkOutput("s2_done",     32'(bus_a.done),        32'd1);
    checkOutput("s2_count",    32'(bus_a.cycle_count), 32'd15);
    checkOutput("s2_halt_src", 32'(bus_a.halt_src),    32'd2);
    checkOutput("s2_timeout",  32'(bus_a.timeout),     32'd0);

    // Halt on the timeout edge: halt wins
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 31);
    checkOutput("s3_count_pre", 32'(bus_a.cycle_count), 32'd29);
    applyStimulus(1'b0, 1'b0, 2'b01, 1'b0, 1);
    checkOutput("s3_timeout_edge", 32'(bus_a.timeout), 32'd0);
    checkOutput("s3_done_edge",    32'(bus_a.done),    32'd0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 4);
    checkOutput("s3_done",     32'(bus_a.done),        32'd1);
    checkOutput("s3_count",    32'(bus_a.cycle_count), 32'd34);
    checkOutput("s3_halt_src", 32'(bus_a.halt_src),    32'd1);
    checkOutput("s3_timeout",  32'(bus_a.timeout),     32'd0);

    // Five paused edges at count 5 push the timeout back five edges
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 7);
    checkOutput("s4_count_pre", 32'(bus_a.cycle_count), 32'd5);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 5);
    checkOutput("s4_count_paused", 32'(bus_a.cycle_count), 32'd5);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 0);
    waitDone(1'b0, 40, edges);
    checkOutput("s4_run_edges", 32'(edges), 32'd25);
    checkOutput("s4_count",     32'(bus_a.cycle_count), 32'd30);
    checkOutput("s4_timeout",   32'(bus_a.timeout),     32'd1);

    // Two halt channels accumulate in DRAIN, then reset mid-drain
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 5);
    applyStimulus(1'b0, 1'b0, 2'b01, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 1);
    checkOutput("s5_halt_src", 32'(bus_a.halt_src), 32'd3);
    checkOutput("s5_run",      32'(bus_a.run),      32'd1);
    checkOutput("s5_done",     32'(bus_a.done),     32'd0);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 1);
    checkOutput("s5_rst_dut_reset", 32'(bus_a.dut_reset),   32'd1);
    checkOutput("s5_rst_run",       32'(bus_a.run),         32'd0);
    checkOutput("s5_rst_count",     32'(bus_a.cycle_count), 32'd0);
    checkOutput("s5_rst_halt_src",  32'(bus_a.halt_src),    32'd0);
    checkOutput("s5_rst_done",      32'(bus_a.done),        32'd0);

    // No timeout, no drain, 4-bit counter saturates
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 2);
    checkOutput("s6_run", 32'(bus_b.run), 32'd1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 15);
    checkOutput("s6_count_full", 32'(bus_b.cycle_count), 32'd15);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 5);
    checkOutput("s6_count_sat", 32'(bus_b.cycle_count), 32'd15);
    checkOutput("s6_no_timeout", 32'(bus_b.timeout), 32'd0);
    checkOutput("s6_not_done",   32'(bus_b.done),    32'd0);
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 1);
    checkOutput("s6_done",     32'(bus_b.done),         32'd1);
    checkOutput("s6_pulse",    32'(bus_b.finish_pulse), 32'd1);
    checkOutput("s6_timeout",  32'(bus_b.timeout),      32'd0);
    checkOutput("s6_count",    32'(bus_b.cycle_count),  32'd15);
    checkOutput("s6_halt_src", 32'(bus_b.halt_src),     32'd1);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1);
    checkOutput("s6_pulse_drop", 32'(bus_b.finish_pulse), 32'd0);
    checkOutput("s6_done_hold",  32'(bus_b.done),         32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
